uart_tx_port: RTL
=================

Name: uart_tx_port

Overview:
- Memory-mapped UART transmitter with a TX FIFO, on the forth_cpu data bus next to ram/timer/led port.
- The top level decodes one memory_selector value, e.g. 5, and drives `sel`.
- Consumes CPU write cycles (mem_valid/mem_nwr/mem_data_in) and returns mem_ready/read data using the same one-cycle handshake as the on-board RAM.
- Raises a "TX done" interrupt into the CPU interrupt vector, cleared by the matching interrupt_ack bit.

Parameters:
FIFO_BITS, 3, log2 of FIFO depth (depth 8)
DEFAULT_DIVISOR, 16'd103, baud divisor after reset; bit period = DIVISOR+1 clk cycles

Ports:
clk  input  1  system clock (cpu_clk domain)
nreset  input  1  asynchronous active-low reset
sel  input  1  address decode for this block, from the top level
mem_valid  input  1  CPU bus cycle valid
mem_nwr  input  1  0 = write, 1 = read
reg_addr  input  1  register select, mem_address[0]
mem_data_in  input  16  write data from CPU
mem_data_out  output  16  registered read data
mem_ready  output  1  bus acknowledge
tx  output  1  serial line, idle high
interrupt  output  1  TX-done interrupt request
interrupt_clear  input  1  interrupt_ack bit from CPU

Behaviour:
- Reset (async, nreset=0):
  - Outputs: tx=1, mem_ready=0, mem_data_out=0, interrupt=0.
  - Internal: FIFO empty (rd/wr ptr=0, count=0), overflow=0, divisor=DEFAULT_DIVISOR, TX FSM=IDLE.
  - Reset mid-frame aborts the frame; tx returns high immediately.
- Bus handshake:
  - access = sel & mem_valid & !mem_ready.
  - mem_ready <= sel & mem_valid each clk, so ready rises 1 cycle after valid and drops 1 cycle after valid falls.
  - Side effects happen only in the access cycle, so exactly once per bus cycle.
- Register map:
  - reg 0 write: push mem_data_in[7:0] to FIFO.
  - reg 0 read: status = {count[7:0] zero-extended, 4'b0, overflow, busy, full, empty}, bits [15:8]=count, [3]=overflow, [2]=busy, [1]=full, [0]=empty. Reading status clears overflow in the same access cycle; the returned value shows the pre-clear value.
  - reg 1 write: divisor <= mem_data_in.
  - reg 1 read: returns divisor.
  - mem_data_out is updated only on read access cycles and holds its value otherwise.
- FIFO:
  - count has width FIFO_BITS+1; full = count==2^FIFO_BITS; empty = count==0. Pointers wrap modulo depth.
  - Push when full: data dropped, overflow<=1, pointers unchanged. Full is the registered value, so a push in the same cycle as a pop while full is still dropped.
  - Push and pop in the same cycle when not full/empty: count unchanged, both pointers advance.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE: if !empty, pop the byte into the shift register, latch divisor into the bit counter reload, go to START. tx goes low on the next cycle.
  - Each state lasts divisor_latched+1 cycles.
  - DATA: 8 bits, LSB first.
  - STOP: tx=1. At end of STOP, if !empty go directly to START with the next byte (no idle gap), else go to IDLE.
  - busy = state != IDLE.
  - A divisor write during a frame affects only the next frame. Divisor 0 gives a 1-cycle bit period.
- Interrupt:
  - Set in the cycle STOP ends with FIFO empty (returning to IDLE).
  - Held until interrupt_clear=1. If set and clear happen in the same cycle, set wins.
  - No set if another byte follows back-to-back.

Test Plan:
- Reset check: assert nreset=0 mid-frame -> tx=1, status read returns 0x0001, divisor reads 103 (0x0067).
- Single byte: write divisor=3, push 0x55 -> tx low 4 clk, then 1,0,1,0,1,0,1,0 each 4 clk, stop high 4 clk. Total 40 clk. Interrupt rises at frame end; interrupt_clear drops it next cycle.
- Back-to-back: push 0xA3 then 0x0F with divisor=1 -> two contiguous 20-clk frames with no idle gap. Exactly one interrupt, after the second stop bit.
- Overflow:
  - Divisor=1000, push 10 bytes 0x00..0x09 while TX stalls on byte 0.
  - Status reads count=8, full=1, overflow=1; a second status read shows overflow=0.
  - Bytes 0x00..0x08 are transmitted; 0x09 is dropped.
- Handshake: hold mem_valid high 5 cycles on a reg 0 write of 0x41 -> mem_ready high from cycle 2 to the cycle after valid drops. Exactly one byte is queued (count=1).
- Divisor change mid-frame: write divisor=7 during a divisor=3 frame -> current frame keeps 4-clk bits, next frame uses 8-clk bits.

Source files
------------

// File: rtl/uart_tx_port_if.sv
// CPU data-bus bundle for the UART transmitter port.
// The CPU side drives the cycle; the port returns ready and read data one cycle later.
interface uart_tx_port_if;
  logic        sel;
  logic        mem_valid;
  logic        mem_nwr;
  logic        reg_addr;
  logic [15:0] mem_data_in;
  logic [15:0] mem_data_out;
  logic        mem_ready;

  modport master (
    output sel,
    output mem_valid,
    output mem_nwr,
    output reg_addr,
    output mem_data_in,
    input  mem_data_out,
    input  mem_ready
  );

  modport slave (
    input  sel,
    input  mem_valid,
    input  mem_nwr,
    input  reg_addr,
    input  mem_data_in,
    output mem_data_out,
    output mem_ready
  );
endinterface

// File: rtl/uart_tx_port.sv
// Memory-mapped UART transmitter for the forth_cpu data bus.
// reg 0: write pushes a byte into the TX FIFO, read returns status (clears overflow).
// reg 1: baud divisor, bit period = divisor + 1 clocks.
// A TX-done interrupt is raised when the last queued byte finishes its stop bit.
module uart_tx_port #(
  parameter int          FIFO_BITS       = 3,
  parameter logic [15:0] DEFAULT_DIVISOR = 16'd103
) (
  input  logic           clk,
  input  logic           nreset,
  uart_tx_port_if.slave  bus,
  output logic           tx,
  output logic           interrupt,
  input  logic           interrupt_clear
);

  localparam int                 DEPTH      = 1 << FIFO_BITS;
  localparam logic [FIFO_BITS:0] FULL_COUNT = (FIFO_BITS+1)'(DEPTH);
  localparam logic [FIFO_BITS:0] CNT_ONE    = (FIFO_BITS+1)'(1);
  localparam logic [FIFO_BITS-1:0] PTR_ONE  = (FIFO_BITS)'(1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  // Status word layout: {count, 4'b0, overflow, busy, full, empty}.
  function automatic logic [15:0] pack_status(
    input logic [FIFO_BITS:0] cnt,
    input logic               ovf,
    input logic               busy_i,
    input logic               full_i,
    input logic               empty_i
  );
    logic [7:0] cnt8;
    cnt8 = 8'(cnt);
    return {cnt8, 4'b0000, ovf, busy_i, full_i, empty_i};
  endfunction

  // Bus decode
  logic access;
  logic wr_data;
  logic wr_div;
  logic rd_acc;
  logic rd_status;

  // FIFO
  logic [7:0]           fifo_mem [DEPTH];
  logic [FIFO_BITS-1:0] wr_ptr;
  logic [FIFO_BITS-1:0] rd_ptr;
  logic [FIFO_BITS:0]   count;
  logic                 full;
  logic                 empty;
  logic                 push_ok;
  logic                 pop;
  logic                 overflow;

  // Registers and transmitter
  logic [15:0] divisor;
  logic [15:0] div_lat;
  logic [15:0] bit_cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shift_reg;
  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic        bit_end;
  logic        frame_done;
  logic        busy;
  logic [15:0] status;

  // Side effects only fire in the first cycle of a bus cycle (ready still low).
  assign access    = bus.sel & bus.mem_valid & ~bus.mem_ready;
  assign wr_data   = access & ~bus.mem_nwr & ~bus.reg_addr;
  assign wr_div    = access & ~bus.mem_nwr &  bus.reg_addr;
  assign rd_acc    = access &  bus.mem_nwr;
  assign rd_status = rd_acc & ~bus.reg_addr;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign push_ok = wr_data & ~full;
  assign busy    = (state != ST_IDLE);
  assign bit_end = (bit_cnt == 16'd0);
  assign status  = pack_status(count, overflow, busy, full, empty);

  // Acknowledge every selected cycle one clock after valid, drop one clock after valid falls.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      bus.mem_ready <= 1'b0;
    end else begin
      bus.mem_ready <= bus.sel & bus.mem_valid;
    end
  end

  // Read data is captured only on a read access and held otherwise.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      bus.mem_data_out <= 16'd0;
    end else if (rd_acc) begin
      bus.mem_data_out <= bus.reg_addr ? divisor : status;
    end
  end

  // Baud divisor register; a running frame keeps its own latched copy.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      divisor <= DEFAULT_DIVISOR;
    end else if (wr_div) begin
      divisor <= bus.mem_data_in;
    end
  end

  // FIFO storage; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_mem[wr_ptr] <= bus.mem_data_in[7:0];
    end
  end

  // FIFO pointers and occupancy; a push while full is dropped even if a pop happens too.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)     rd_ptr <= rd_ptr + PTR_ONE;
      case ({push_ok, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow flag; the status read returns the old value and clears it.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      overflow <= 1'b0;
    end else if (wr_data & full) begin
      overflow <= 1'b1;
    end else if (rd_status) begin
      overflow <= 1'b0;
    end
  end

  // Next-state logic for the frame sequencer; pops happen on frame start.
  always_comb begin
    state_nxt  = state;
    pop        = 1'b0;
    frame_done = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          state_nxt = ST_START;
        end
      end
      ST_START: begin
        if (bit_end) state_nxt = ST_DATA;
      end
      ST_DATA: begin
        if (bit_end && (bit_idx == 3'd7)) state_nxt = ST_STOP;
      end
      ST_STOP: begin
        if (bit_end) begin
          if (!empty) begin
            pop       = 1'b1;
            state_nxt = ST_START;
          end else begin
            state_nxt  = ST_IDLE;
            frame_done = 1'b1;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Sequencer state, per-bit cycle counter and data bit index.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state   <= ST_IDLE;
      bit_cnt <= 16'd0;
      bit_idx <= 3'd0;
    end else begin
      state <= state_nxt;
      if (pop) begin
        bit_cnt <= divisor;
        bit_idx <= 3'd0;
      end else if (state != ST_IDLE) begin
        if (bit_end) begin
          bit_cnt <= div_lat;
          if (state == ST_DATA) bit_idx <= bit_idx + 3'd1;
        end else begin
          bit_cnt <= bit_cnt - 16'd1;
        end
      end
    end
  end

  // Frame datapath: load byte and divisor on pop, shift LSB-first after each data bit.
  always_ff @(posedge clk) begin
    if (pop) begin
      shift_reg <= fifo_mem[rd_ptr];
      div_lat   <= divisor;
    end else if ((state == ST_DATA) && bit_end) begin
      shift_reg <= {1'b0, shift_reg[7:1]};
    end
  end

  // Serial line decoded from state so reset returns it high immediately.
  always_comb begin
    case (state)
      ST_START: tx = 1'b0;
      ST_DATA:  tx = shift_reg[0];
      default:  tx = 1'b1;
    endcase
  end

  // TX-done interrupt: set when the queue drains at stop end; set beats clear.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      interrupt <= 1'b0;
    end else if (frame_done) begin
      interrupt <= 1'b1;
    end else if (interrupt_clear) begin
      interrupt <= 1'b0;
    end
  end

endmodule
